// File: rtl/paddle_reader.sv
// Multi-channel RC paddle timer: measures each comparator rise against the frame's
// scanline count and publishes one position per channel at every frame start.
module paddle_reader #(
   parameter int               NUM_PADDLES = 2,
   parameter int               CNT_W       = 8,
   parameter int               SYNC_STAGES = 2,
   parameter int               DUMP_LINES  = 4,
   parameter logic [CNT_W-1:0] TIMEOUT_VAL = '1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         line_strobe,
   input  logic                         frame_strobe,
   input  logic [NUM_PADDLES-1:0]       paddle_in,
   output logic                         paddle_dump,
   output logic [NUM_PADDLES*CNT_W-1:0] paddle_pos,
   output logic [NUM_PADDLES-1:0]       pos_valid,
   output logic                         frame_done
);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] DUMP_CNT = CNT_W'(DUMP_LINES);

   logic [CNT_W-1:0]     line_cnt_q, line_cnt_d;
   logic                 dump_q;
   logic                 frame_done_q;
   logic [SYNC_STAGES:0] settle_q;
   logic                 settled;

   always_comb begin
      line_cnt_d = line_cnt_q;
      if (frame_strobe)
         line_cnt_d = '0;
      else if (line_strobe && (line_cnt_q != CNT_MAX))
         line_cnt_d = line_cnt_q + CNT_W'(1);
   end

   // Edges stay masked until the synchroniser and edge flop hold real pin samples,
   // so a pin already high at reset release never looks like a rise.
   assign settled = settle_q[SYNC_STAGES];

   always_ff @(posedge clk) begin
      if (reset) begin
         line_cnt_q   <= '0;
         dump_q       <= 1'b1;
         frame_done_q <= 1'b0;
         settle_q     <= '0;
      end else begin
         line_cnt_q   <= line_cnt_d;
         dump_q       <= (line_cnt_q < DUMP_CNT);
         frame_done_q <= frame_strobe;
         settle_q     <= {settle_q[SYNC_STAGES-1:0], 1'b1};
      end
   end

   assign paddle_dump = dump_q;
   assign frame_done  = frame_done_q;

   for (genvar gi = 0; gi < NUM_PADDLES; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   prev_q;
      logic                   rise;
      logic                   captured_q, captured_d;
      logic [CNT_W-1:0]       cap_val_q, cap_val_d;
      logic [CNT_W-1:0]       pos_q;
      logic                   valid_q;

      assign rise = sync_q[SYNC_STAGES-1] & ~prev_q & settled;

      // A rise coinciding with frame_strobe belongs to the new frame's dump window.
      always_comb begin
         captured_d = captured_q;
         cap_val_d  = cap_val_q;
         if (frame_strobe) begin
            captured_d = 1'b0;
            cap_val_d  = '0;
         end else if (rise && !dump_q && !captured_q) begin
            captured_d = 1'b1;
            cap_val_d  = line_cnt_q;
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            sync_q     <= '0;
            prev_q     <= 1'b0;
            captured_q <= 1'b0;
            cap_val_q  <= '0;
            pos_q      <= '0;
            valid_q    <= 1'b0;
         end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], paddle_in[gi]};
            prev_q     <= sync_q[SYNC_STAGES-1];
            captured_q <= captured_d;
            cap_val_q  <= cap_val_d;
            if (frame_strobe) begin
               pos_q   <= captured_q ? cap_val_q : TIMEOUT_VAL;
               valid_q <= captured_q;
            end
         end
      end

      assign paddle_pos[gi*CNT_W +: CNT_W] = pos_q;
      assign pos_valid[gi]                 = valid_q;
   end

endmodule
